// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes and byte-lane helpers shared by the register file write and bypass paths
package regfile_pkg;
  localparam int REGF_WIDTH = 32;
  localparam int REGF_DEPTH = 32;
  typedef struct packed {
    logic       hit;
    logic [7:0] data;
  } lane_t;
  function automatic int lanes(input int width);
    return width / 8;
  endfunction
  // Port A owns every lane it writes; port B only fills lanes that A leaves untouched.
  function automatic lane_t merge_lane(input logic a, input logic [7:0] a_data, input logic b, input logic [7:0] b_data);
    return lane_t'{hit: a | b, data: a ? a_data : b_data};
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: range check, zero-register forcing and per-lane write bypass for one read port
module regfile_read_port import regfile_pkg::*; #(
  parameter int WIDTH = REGF_WIDTH,
  parameter int DEPTH = REGF_DEPTH,
  parameter int AW = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic               r,
  input  logic [AW-1:0]      addr,
  input  logic [WIDTH-1:0]   mem [DEPTH],
  input  logic               en3,
  input  logic [AW-1:0]      addr3,
  input  logic [WIDTH-1:0]   data3,
  input  logic [WIDTH/8-1:0] mask3,
  input  logic               en4,
  input  logic [AW-1:0]      addr4,
  input  logic [WIDTH-1:0]   data4,
  input  logic [WIDTH/8-1:0] mask4,
  output logic [WIDTH-1:0]   data
);
  localparam int L = lanes(WIDTH);
  logic valid, hit3, hit4;
  logic [WIDTH-1:0] stored;
  lane_t lane;
  assign valid = int'(addr) < DEPTH && !(ZERO_REG != 0 && addr == '0);
  assign stored = valid ? mem[addr] : '0;
  // Bypass is held off during reset so reads show storage, not the doomed write.
  assign hit3 = BYPASS != 0 && r && valid && en3 && addr3 == addr;
  assign hit4 = BYPASS != 0 && r && valid && en4 && addr4 == addr;
  always_comb begin
    data = stored;
    lane = '0;
    for (int l = 0; l < L; l++) begin
      lane = merge_lane(hit3 && mask3[l], data3[8*l+:8], hit4 && mask4[l], data4[8*l+:8]);
      data[8*l+:8] = lane.hit ? lane.data : stored[8*l+:8];
    end
  end
endmodule

// File: rtl/param_register_file.sv
// param_register_file: parameterised register file with two prioritised byte-masked write ports and two read ports
module param_register_file import regfile_pkg::*; #(
  parameter int WIDTH = REGF_WIDTH,
  parameter int DEPTH = REGF_DEPTH,
  parameter int AW = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic               Clock,
  input  logic               R,
  input  logic               WriteEn3,
  input  logic [AW-1:0]      WriteReg3,
  input  logic [WIDTH-1:0]   wd3,
  input  logic [WIDTH/8-1:0] WriteMask3,
  input  logic               WriteEn4,
  input  logic [AW-1:0]      WriteReg4,
  input  logic [WIDTH-1:0]   wd4,
  input  logic [WIDTH/8-1:0] WriteMask4,
  input  logic [AW-1:0]      ReadReg1,
  output logic [WIDTH-1:0]   ReadData1,
  input  logic [AW-1:0]      ReadReg2,
  output logic [WIDTH-1:0]   ReadData2
);
  localparam int L = lanes(WIDTH);
  if (WIDTH % 8 != 0 || DEPTH < 2) begin : g_bad_params
    $error("param_register_file: WIDTH must be a multiple of 8 and DEPTH at least 2");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] nxt [DEPTH];
  logic ok3, ok4;
  lane_t lane;
  assign ok3 = WriteEn3 && int'(WriteReg3) < DEPTH && !(ZERO_REG != 0 && WriteReg3 == '0);
  assign ok4 = WriteEn4 && int'(WriteReg4) < DEPTH && !(ZERO_REG != 0 && WriteReg4 == '0);
  always_comb begin
    nxt = mem;
    lane = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int l = 0; l < L; l++) begin
        lane = merge_lane(ok3 && int'(WriteReg3) == i && WriteMask3[l], wd3[8*l+:8],
                          ok4 && int'(WriteReg4) == i && WriteMask4[l], wd4[8*l+:8]);
        nxt[i][8*l+:8] = lane.hit ? lane.data : mem[i][8*l+:8];
      end
  end
  always_ff @(posedge Clock)
    if (!R) mem <= '{default: '0};
    else mem <= nxt;
  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd1 (
    .r(R), .addr(ReadReg1), .mem(mem),
    .en3(WriteEn3), .addr3(WriteReg3), .data3(wd3), .mask3(WriteMask3),
    .en4(WriteEn4), .addr4(WriteReg4), .data4(wd4), .mask4(WriteMask4),
    .data(ReadData1)
  );
  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd2 (
    .r(R), .addr(ReadReg2), .mem(mem),
    .en3(WriteEn3), .addr3(WriteReg3), .data3(wd3), .mask3(WriteMask3),
    .en4(WriteEn4), .addr4(WriteReg4), .data4(wd4), .mask4(WriteMask4),
    .data(ReadData2)
  );
endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: default instance plus a 64x20 no-zero-reg no-bypass instance, checked against a lane-level model
module tb_param_register_file;
  logic clk = 0;
  logic r, we3, we4;
  logic [4:0] wa3, wa4, ra1, ra2;
  logic [63:0] wd3, wd4;
  logic [7:0] mk3, mk4;
  logic [31:0] rd1_0, rd2_0;
  logic [63:0] rd1_1, rd2_1;
  logic [63:0] m0 [32];
  logic [63:0] m1 [32];
  int checks = 0, errors = 0;
  logic chk_on = 0;
  always #5 clk = ~clk;
  param_register_file d0 (
    .Clock(clk), .R(r),
    .WriteEn3(we3), .WriteReg3(wa3), .wd3(wd3[31:0]), .WriteMask3(mk3[3:0]),
    .WriteEn4(we4), .WriteReg4(wa4), .wd4(wd4[31:0]), .WriteMask4(mk4[3:0]),
    .ReadReg1(ra1), .ReadData1(rd1_0), .ReadReg2(ra2), .ReadData2(rd2_0)
  );
  param_register_file #(.WIDTH(64), .DEPTH(20), .ZERO_REG(0), .BYPASS(0)) d1 (
    .Clock(clk), .R(r),
    .WriteEn3(we3), .WriteReg3(wa3), .wd3(wd3), .WriteMask3(mk3),
    .WriteEn4(we4), .WriteReg4(wa4), .wd4(wd4), .WriteMask4(mk4),
    .ReadReg1(ra1), .ReadData1(rd1_1), .ReadReg2(ra2), .ReadData2(rd2_1)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // cfg 0 = 32x32 with zero reg and bypass, cfg 1 = 64x20 plain
  function automatic logic ok(input int c, input logic [4:0] a);
    return c != 0 ? a < 20 : a != 0;
  endfunction
  function automatic logic [63:0] exp_rd(input int c, input logic [4:0] a);
    logic [63:0] v;
    if (!ok(c, a)) return 64'h0;
    v = c != 0 ? m1[a] : m0[a];
    if (c == 0 && r)
      for (int b = 0; b < 4; b++)
        if (we3 && wa3 == a && mk3[b]) v[8*b+:8] = wd3[8*b+:8];
        else if (we4 && wa4 == a && mk4[b]) v[8*b+:8] = wd4[8*b+:8];
    return c != 0 ? v : {32'h0, v[31:0]};
  endfunction
  // Port B lands first, port A overwrites it lane by lane.
  always @(posedge clk)
    if (!r) begin
      for (int i = 0; i < 32; i++) begin
        m0[i] <= 64'h0;
        m1[i] <= 64'h0;
      end
    end else
      for (int b = 0; b < 8; b++) begin
        if (we4 && mk4[b]) begin
          if (b < 4 && ok(0, wa4)) m0[wa4][8*b+:8] <= wd4[8*b+:8];
          if (ok(1, wa4)) m1[wa4][8*b+:8] <= wd4[8*b+:8];
        end
        if (we3 && mk3[b]) begin
          if (b < 4 && ok(0, wa3)) m0[wa3][8*b+:8] <= wd3[8*b+:8];
          if (ok(1, wa3)) m1[wa3][8*b+:8] <= wd3[8*b+:8];
        end
      end
  always @(negedge clk)
    if (chk_on) begin
      chk("d0_rd1", {32'h0, rd1_0}, exp_rd(0, ra1));
      chk("d0_rd2", {32'h0, rd2_0}, exp_rd(0, ra2));
      chk("d1_rd1", rd1_1, exp_rd(1, ra1));
      chk("d1_rd2", rd2_1, exp_rd(1, ra2));
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr3(input logic [4:0] a, input logic [63:0] d, input logic [7:0] m);
    we3 = 1; wa3 = a; wd3 = d; mk3 = m;
  endtask
  initial begin
    r = 0; we3 = 0; we4 = 0; wa3 = 0; wa4 = 0; wd3 = 0; wd4 = 0; mk3 = 0; mk4 = 0; ra1 = 0; ra2 = 0;
    tick;
    chk_on = 1;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      wr3(5'(i), 64'(i), 8'hFF);
      tick;
    end
    r = 0; wr3(5, 64'hDEADBEEF, 8'hFF); ra1 = 5; ra2 = 7;
    #1;
    chk("rst_pre_d0", {32'h0, rd1_0}, 64'd5);
    chk("rst_pre_d1", rd1_1, 64'd5);
    tick;
    r = 1; we3 = 0;
    #1;
    chk("rst_d0_r5", {32'h0, rd1_0}, 64'h0);
    chk("rst_d0_r7", {32'h0, rd2_0}, 64'h0);
    chk("rst_d1_r5", rd1_1, 64'h0);
    chk("rst_d1_r7", rd2_1, 64'h0);
    for (int i = 0; i < 32; i++) begin
      wr3(5'(i), 64'(i), 8'hFF);
      tick;
    end
    we3 = 0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      #1;
      chk("sweep_d0", {32'h0, rd1_0}, i == 0 ? 64'h0 : 64'(i));
      chk("sweep_d1", rd1_1, i < 20 ? 64'(i) : 64'h0);
    end
    wr3(3, 64'h11223344, 8'hFF);
    tick;
    wr3(3, 64'hAABBCCDD, 8'h05);
    tick;
    we3 = 0; ra1 = 3;
    #1;
    chk("mask_d0", {32'h0, rd1_0}, 64'h11BB33DD);
    chk("mask_d1", rd1_1, 64'h11BB33DD);
    wr3(7, 64'hFFFF0000, 8'h0C);
    we4 = 1; wa4 = 7; wd4 = 64'h12345678; mk4 = 8'h0F;
    tick;
    we3 = 0; we4 = 0; ra1 = 7;
    #1;
    chk("coll_d0", {32'h0, rd1_0}, 64'hFFFF5678);
    chk("coll_d1", rd1_1, 64'hFFFF5678);
    ra1 = 9; wr3(9, 64'h7FFFFFFF, 8'hFF);
    #1;
    chk("byp_d0", {32'h0, rd1_0}, 64'h7FFFFFFF);
    chk("nobyp_old_d1", rd1_1, 64'd9);
    tick;
    we3 = 0;
    #1;
    chk("nobyp_new_d1", rd1_1, 64'h7FFFFFFF);
    wr3(19, 64'h8000000000000000, 8'hFF);
    tick;
    wr3(25, 64'h1234, 8'hFF);
    tick;
    we3 = 0; ra1 = 19; ra2 = 25;
    #1;
    chk("wide_d1_r19", rd1_1, 64'h8000000000000000);
    chk("oor_d1_r25", rd2_1, 64'h0);
    chk("wide_d0_r19", {32'h0, rd1_0}, 64'h0);
    chk("d0_r25", {32'h0, rd2_0}, 64'h1234);
    wr3(0, 64'h5555, 8'hFF); ra1 = 0;
    #1;
    chk("zero_byp_d0", {32'h0, rd1_0}, 64'h0);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 49) != 0;
      we3 = 1'($urandom); we4 = 1'($urandom);
      wa3 = 5'($urandom);
      wa4 = $urandom_range(0, 1) != 0 ? wa3 : 5'($urandom);
      wd3 = {$urandom, $urandom}; wd4 = {$urandom, $urandom};
      mk3 = 8'($urandom); mk4 = 8'($urandom);
      ra1 = $urandom_range(0, 1) != 0 ? wa3 : 5'($urandom);
      ra2 = $urandom_range(0, 2) == 0 ? wa4 : 5'($urandom);
      tick;
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised successor to the 32×32 two-read/one-write register file. It has configurable word width and depth, and two write ports with fixed priority. Each write port has byte-lane write masks. Optional features are a hardwired zero register and write-to-read bypass. It sits in the datapath between writeback and operand fetch, where one write port serves the ALU result and the other serves the load result.

## Interface
- WIDTH, 32: data word width in bits. Must be a multiple of 8.
- DEPTH, 32: number of registers. Range 2..256; need not be a power of two.
- AW, $clog2(DEPTH): address width. Derived; do not override.
- ZERO_REG, 1: when 1, register 0 always reads 0 and writes to it are dropped.
- BYPASS, 1: when 1, a read of an address being written this cycle returns the incoming write data.

- Clock  in  1  single clock; all state updates on rising edge.
- R  in  1  reset; synchronous, active-low.
- WriteEn3  in  1  write port A enable.
- WriteReg3  in  AW  write port A address.
- wd3  in  WIDTH  write port A data.
- WriteMask3  in  WIDTH/8  write port A byte-lane enables; bit i covers bits [8i+7:8i].
- WriteEn4  in  1  write port B enable.
- WriteReg4  in  AW  write port B address.
- wd4  in  WIDTH  write port B data.
- WriteMask4  in  WIDTH/8  write port B byte-lane enables.
- ReadReg1  in  AW  read port 1 address.
- ReadData1  out  WIDTH  read port 1 data.
- ReadReg2  in  AW  read port 2 address.
- ReadData2  out  WIDTH  read port 2 data.

## Operation
- Storage: DEPTH words of WIDTH bits.
- Reset: a rising edge with R=0 clears every register to 0. Both write ports are ignored on that edge.
- Write: on a rising edge with R=1, a port writes when WriteEnX=1, the address is < DEPTH and is not register 0 under ZERO_REG=1.
- Masking: only byte lanes with the mask bit set are updated; other lanes hold their value. A mask of all zeros is a no-op.
- Collision (both ports enabled, same address): port A (3) wins per byte lane where its mask bit is set. Port B (4) updates only lanes where A's mask is 0 and B's mask is 1.
- Read: ReadDataN shows the stored word at ReadRegN.
- Read, address ≥ DEPTH: returns 0.
- Read, register 0 under ZERO_REG=1: returns 0.
- Bypass (BYPASS=1): for each byte lane, read data is taken from the winning pending write to the same valid address, using the collision rule above. Lanes with no pending write come from storage.
- Bypass never applies to register 0 under ZERO_REG=1 or to out-of-range addresses.
- Bypass is suppressed while R=0; reads then return stored contents.
- BYPASS=0: reads show the pre-edge contents. New data is visible the cycle after the write edge.

## Timing
- Write latency: 1 edge. Data is in storage after the rising edge on which the enable is sampled.
- Read latency: combinational, 0 cycles from ReadRegN to ReadDataN.
- Bypass path: combinational from wdX, WriteRegX, WriteEnX and WriteMaskX to ReadDataN within the same cycle.
- Reset value: every register is 0. After the reset edge, ReadData1 = ReadData2 = 0 for all addresses.
- Reset mid-operation: R=0 sampled together with a write means the write is lost and all registers are 0 after the edge. R has priority over all writes.
- Both read ports may address the same register, or the register being written, at once. There is no stall and no arbitration.

## Structure
- Package regfile_pkg holds:
  - default parameter constants (REGF_WIDTH=32, REGF_DEPTH=32);
  - the byte-lane count function (lanes = width/8);
  - the lane-merge function implementing the A-over-B priority, shared by the write path and the bypass path.
- Sub-module regfile_read_port: one instance per read port. It contains address range check, zero-register forcing and the per-lane bypass mux.
- Top level holds the storage array, the reset and write logic, and two regfile_read_port instances.
- Elaboration-time check: fail if WIDTH % 8 ≠ 0 or DEPTH < 2.

## Test plan
- Reset: preload registers 1..31 with their index, drive R=0 for one edge → all reads 0. A write of 0xDEADBEEF to register 5 on the reset edge → register 5 reads 0.
- Sweep, defaults: write register i ← i for i = 0..31, then read all → ReadData1 = i for i ≥ 1, and register 0 reads 0. Repeat with ZERO_REG=0 → register 0 reads 0 after writing 0.
- Byte mask: register 3 = 0x11223344; port A writes 0xAABBCCDD with mask 0b0101 → register 3 = 0x11BB33DD.
- Collision: port A writes 0xFFFF0000 to register 7 with mask 0b1100; port B writes 0x12345678 to register 7 with mask 0b1111 → register 7 = 0xFFFF5678.
- Bypass: BYPASS=1, ReadReg1 = 9, port A writes 0x7FFFFFFF to register 9 → ReadData1 = 0x7FFFFFFF in the same cycle. With BYPASS=0 → old value until the edge, then 0x7FFFFFFF.
- Parameters: WIDTH=64, DEPTH=20; write 0x8000000000000000 to register 19 → it reads back unchanged. A write to address 25 is dropped, and reading 25 → 0.
